// File: rtl/mmio_uart_tx_if.sv
// Core-side data bus seen by the memory-mapped UART transmitter.
// The core drives address/data/strobes; the peripheral returns read data and its select.
interface mmio_uart_tx_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wenable;
    logic [31:0] bus_rdata;
    logic        hit;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_wenable,
        input  bus_rdata,
        input  hit
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_wenable,
        output bus_rdata,
        output hit
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a bus-fed TX FIFO drained by a serialising FSM.
// Registers: DATA (push), STATUS (flags, count, sticky overflow), DIV (bit period - 1).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          tx_active
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [1:0] SEL_DATA   = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_DIV    = 2'd2;

    logic [1:0]       reg_sel;
    logic             wr_data;
    logic             wr_clear_ovf;
    logic             wr_div_lo;
    logic             wr_div_hi;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push_ok;
    logic             pop;
    logic             overflow;
    logic [15:0]      div;
    logic             busy;

    state_t           state, state_n;
    logic [15:0]      bit_cnt, bit_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift_reg, shift_n;
    logic             tx_n;
    logic             tx_active_n;
    logic             bit_done;

    logic             unused_bus_bits;

    assign unused_bus_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:16], bus.bus_wenable[3:2]};

    // Address decode: only the upper 28 bits select the window, bits [3:2] pick the register.
    assign bus.hit      = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel      = bus.bus_addr[3:2];
    assign wr_data      = bus.hit && (reg_sel == SEL_DATA)   && bus.bus_wenable[0];
    assign wr_clear_ovf = bus.hit && (reg_sel == SEL_STATUS) && bus.bus_wenable[0] && bus.bus_wdata[3];
    assign wr_div_lo    = bus.hit && (reg_sel == SEL_DIV)    && bus.bus_wenable[0];
    assign wr_div_hi    = bus.hit && (reg_sel == SEL_DIV)    && bus.bus_wenable[1];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign push_ok    = wr_data && !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.bus_wdata[7:0];
        end
    end

    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost even if the FSM drains a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wr_data && fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= DEFAULT_DIV;
        end else begin
            if (wr_div_lo) begin
                div[7:0] <= bus.bus_wdata[7:0];
            end
            if (wr_div_hi) begin
                div[15:8] <= bus.bus_wdata[15:8];
            end
        end
    end

    always_comb begin
        bus.bus_rdata = '0;
        if (bus.hit) begin
            case (reg_sel)
                SEL_STATUS: bus.bus_rdata = {16'b0, 8'(count), 4'b0, overflow, busy, fifo_full, fifo_empty};
                SEL_DIV:    bus.bus_rdata = {16'b0, div};
                default:    bus.bus_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_active <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
            tx        <= tx_n;
            tx_active <= tx_active_n;
        end
    end

    // Every bit reloads the counter from the live DIV, so a mid-frame DIV write only affects later bits.
    assign bit_done = (bit_cnt == '0);

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift_reg;
        tx_n        = tx;
        tx_active_n = tx_active;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_n     = fifo_mem[rd_ptr];
                    state_n     = START;
                    tx_n        = 1'b0;
                    tx_active_n = 1'b1;
                    bit_cnt_n   = div;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n   = DATA;
                    tx_n      = shift_reg[0];
                    shift_n   = {1'b0, shift_reg[7:1]};
                    bit_idx_n = '0;
                    bit_cnt_n = div;
                end else begin
                    bit_cnt_n = bit_cnt - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_cnt_n = div;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shift_reg[0];
                        shift_n   = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    bit_cnt_n = bit_cnt - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    // Chain straight into the next start bit so back-to-back bytes leave no idle gap.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_n   = fifo_mem[rd_ptr];
                        state_n   = START;
                        tx_n      = 1'b0;
                        bit_cnt_n = div;
                    end else begin
                        state_n     = IDLE;
                        tx_active_n = 1'b0;
                    end
                end else begin
                    bit_cnt_n = bit_cnt - 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed register/line checks plus randomized frames
// compared cycle by cycle against an arithmetic model of the 8N1 waveform and FIFO occupancy.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic tx_active;

    always #5 clk = ~clk;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd433)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .tx       (tx),
        .tx_active(tx_active)
    );

    int          nChecks = 0;
    int          nFails  = 0;
    logic        txLog  [$];
    logic        actLog [$];
    logic [31:0] stLog  [$];
    logic [7:0]  txBytes [4];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: after the edge the bus returns to an idle STATUS read, then outputs are logged.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.bus_wenable = 4'b0000;
        bus.bus_wdata   = 32'h0;
        bus.bus_addr    = BASE + 32'h4;
        #1;
        txLog.push_back(tx);
        actLog.push_back(tx_active);
        stLog.push_back(bus.bus_rdata);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wen);
        bus.bus_addr    = addr;
        bus.bus_wdata   = data;
        bus.bus_wenable = wen;
        tick();
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
        bus.bus_addr    = addr;
        bus.bus_wenable = 4'b0000;
        #1;
        data = bus.bus_rdata;
    endtask

    function automatic logic frameBit(input logic [7:0] b, input int p, input int off);
        int slot;
        slot = off / p;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // Frame f starts at log index e0+10p*f; byte i is pushed at log index e0-1+i.
    task automatic runFrames(input int div, input int n);
        int e0, p, fl, total, pushed, started, cnt, bsy;
        logic [31:0] expSt;
        applyStimulus(BASE + 32'h8, 32'(div), 4'b0011);
        applyStimulus(BASE, {24'h0, txBytes[0]}, 4'b0001);
        e0 = txLog.size();
        for (int i = 1; i < n; i++) applyStimulus(BASE, {24'h0, txBytes[i]}, 4'b0001);
        p  = div + 1;
        fl = 10 * p;
        total = fl * n;
        while (txLog.size() < e0 + total + 2) tick();
        checkOutput("tx before first start bit", 32'(txLog[e0-1]), 32'h1);
        for (int k = -1; k <= total + 1; k++) begin
            pushed  = (k + 2 < n) ? k + 2 : n;
            started = (k < 0) ? 0 : (((k / fl) + 1 < n) ? (k / fl) + 1 : n);
            cnt     = pushed - started;
            bsy     = ((k >= 0 && k < total) || cnt != 0) ? 1 : 0;
            expSt   = (32'(cnt) << 8) | (32'(bsy) << 2) | ((cnt == 0) ? 32'h1 : 32'h0);
            checkOutput("status during frames", stLog[e0+k], expSt);
            if (k >= 0) begin
                checkOutput("tx line", 32'(txLog[e0+k]),
                            (k < total) ? 32'(frameBit(txBytes[k/fl], p, k % fl)) : 32'h1);
                checkOutput("tx_active", 32'(actLog[e0+k]), (k < total) ? 32'h1 : 32'h0);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          e0;
        int          slot;
        logic        expTx;
        logic [7:0]  b55;

        rst             = 1'b1;
        bus.bus_addr    = BASE + 32'h4;
        bus.bus_wdata   = 32'h0;
        bus.bus_wenable = 4'b0000;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and register map
        readReg(BASE + 32'h4, rd);
        checkOutput("reset STATUS", rd, 32'h0000_0001);
        checkOutput("hit in window", 32'(bus.hit), 32'h1);
        readReg(BASE + 32'h8, rd);
        checkOutput("reset DIV", rd, 32'd433);
        checkOutput("reset tx", 32'(tx), 32'h1);
        checkOutput("reset tx_active", 32'(tx_active), 32'h0);
        readReg(BASE + 32'h0, rd);
        checkOutput("DATA reads zero", rd, 32'h0);

        applyStimulus(BASE + 32'h8, 32'h0000_ABCD, 4'b0001);
        readReg(BASE + 32'h8, rd);
        checkOutput("DIV low lane", rd, 32'h0000_01CD);
        applyStimulus(BASE + 32'h8, 32'h0000_1234, 4'b0010);
        readReg(BASE + 32'h8, rd);
        checkOutput("DIV high lane", rd, 32'h0000_12CD);
        applyStimulus(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111);
        readReg(BASE + 32'hC, rd);
        checkOutput("reserved reads zero", rd, 32'h0);
        readReg(BASE + 32'h8, rd);
        checkOutput("reserved write ignored", rd, 32'h0000_12CD);

        $display("[TB] single frame DIV=3 byte 0x55");
        txBytes[0] = 8'h55;
        runFrames(3, 1);

        $display("[TB] back-to-back frames DIV=1");
        txBytes[0] = 8'h41;
        txBytes[1] = 8'h42;
        txBytes[2] = 8'h43;
        runFrames(1, 3);

        $display("[TB] randomized frames");
        for (int it = 0; it < 6; it++) begin
            int d, n;
            d = (it == 0) ? 0 : int'($urandom_range(0, 4));
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) txBytes[i] = 8'($urandom);
            runFrames(d, n);
        end

        $display("[TB] mid-frame DIV change");
        b55 = 8'h55;
        applyStimulus(BASE + 32'h8, 32'd3, 4'b0011);
        applyStimulus(BASE, 32'h55, 4'b0001);
        e0 = txLog.size();
        tick();
        applyStimulus(BASE + 32'h8, 32'd7, 4'b0011);
        while (txLog.size() < e0 + 78) tick();
        for (int k = 0; k <= 76; k++) begin
            if (k < 4) begin
                expTx = 1'b0;
            end else begin
                slot  = 1 + (k - 4) / 8;
                expTx = (k < 76 && slot <= 8) ? b55[slot-1] : 1'b1;
            end
            checkOutput("tx after DIV change", 32'(txLog[e0+k]), 32'(expTx));
            checkOutput("tx_active after DIV change", 32'(actLog[e0+k]), (k < 76) ? 32'h1 : 32'h0);
        end

        $display("[TB] overflow and mid-frame reset");
        applyStimulus(BASE + 32'h8, 32'd100, 4'b0011);
        for (int i = 0; i < 10; i++) applyStimulus(BASE, 32'(i), 4'b0001);
        readReg(BASE + 32'h4, rd);
        checkOutput("STATUS full+overflow", rd, 32'h0000_080E);
        applyStimulus(BASE + 32'h4, 32'h8, 4'b0001);
        readReg(BASE + 32'h4, rd);
        checkOutput("STATUS overflow cleared", rd, 32'h0000_0806);
        for (int i = 0; i < 140; i++) tick();
        checkOutput("active mid DATA", 32'(tx_active), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("tx after reset", 32'(tx), 32'h1);
        checkOutput("tx_active after reset", 32'(tx_active), 32'h0);
        checkOutput("STATUS after reset", stLog[stLog.size()-1], 32'h0000_0001);
        readReg(BASE + 32'h8, rd);
        checkOutput("DIV after reset", rd, 32'd433);

        readReg(BASE + 32'h10, rd);
        checkOutput("out of window hit", 32'(bus.hit), 32'h0);
        checkOutput("out of window rdata", rd, 32'h0);
        applyStimulus(BASE + 32'h10, 32'hAA, 4'b1111);
        tick();
        tick();
        readReg(BASE + 32'h4, rd);
        checkOutput("STATUS after stray store", rd, 32'h0000_0001);
        checkOutput("tx idle after stray store", 32'(tx), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
